async_fifo_lvl: RTL
===================

Name: async_fifo_lvl

Overview:
- Parametrised dual-clock FIFO. Successor to the team's fixed 16x8 gray-pointer asynchronous FIFO.
- Adds configurable synchroniser depth, registered full/empty flags, per-domain fill levels, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags.
- Optional first-word-fall-through (FWFT) read mode.
- Sits at clock-domain boundaries between streaming producers and consumers.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries (ADDR_W >= 2).
- SYNC_STAGES, 2, flops per gray-pointer synchroniser chain (2..4).
- AFULL_THRESH, DEPTH-2, almost_full asserts when wr_level >= this value.
- AEMPTY_THRESH, 2, almost_empty asserts when rd_level <= this value.

Ports:
- wr_clk  in  1  write clock
- wr_reset_n  in  1  write-domain reset
- rd_clk  in  1  read clock
- rd_reset_n  in  1  read-domain reset, asynchronous, active-low
- wr_en  in  1  write request
- wr_data  in  DATA_W  write data
- full  out  1  FIFO full (wr domain, registered)
- almost_full  out  1  wr_level >= AFULL_THRESH
- wr_level  out  ADDR_W+1  occupancy seen by write side, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- ovf_clr  in  1  clears overflow
- rd_en  in  1  read request
- rd_data  out  DATA_W  read data
- rd_valid  out  1  rd_data qualifier
- empty  out  1  FIFO empty (rd domain, registered)
- almost_empty  out  1  rd_level <= AEMPTY_THRESH
- rd_level  out  ADDR_W+1  occupancy seen by read side
- underflow  out  1  sticky: read attempted while empty
- udf_clr  in  1  clears underflow

Interface decision: reset wr_reset_n, asynchronous, active-low; clock wr_clk. rd_reset_n and rd_clk mirror it for the read domain.

Behaviour:
- Pointers: ADDR_W+1-bit binary and registered gray pointers per domain; memory indexed by the low ADDR_W bits; wrap is natural modulo 2**(ADDR_W+1).
- Only gray pointers cross domains, through SYNC_STAGES-deep flop chains clocked by the destination clock and reset by the destination reset.
- Write accept: accept = wr_en && !full. On accept: mem[wptr] <= wr_data and the pointer increments.
- full register: full <= (wgray_next == synced rgray with its top two bits inverted).
- Read accept (non-FWFT): accept = rd_en && !empty. rd_data <= mem[rptr]; rd_valid pulses one rd_clk cycle after accept; latency is 1.
- empty register: empty <= (rgray_next == synced wgray).
- Levels:
  - wr_level <= wbin_next - gray2bin(synced rgray), registered.
  - rd_level <= gray2bin(synced wgray) - rbin_next, registered.
  - Unsigned, ADDR_W+1 bits, never exceeding DEPTH.
  - Levels are pessimistic: wr_level may over-report and rd_level may under-report by up to SYNC_STAGES+1 cycles of remote activity.
- almost_full and almost_empty are registered and use the same next-state levels as wr_level and rd_level.
- Latency to the remote domain:
  - A write into an empty FIFO deasserts empty within SYNC_STAGES+2 rd_clk edges.
  - A read from a full FIFO deasserts full within SYNC_STAGES+2 wr_clk edges.
- Error flags:
  - overflow is set on wr_en && full; the write is dropped and the memory and pointers are unchanged. It holds until ovf_clr; if set and clear occur in the same cycle, set wins.
  - underflow behaves the same way with rd_en && empty and udf_clr.
- Simultaneous write and read in the same instant are always legal, including at full and at empty.
- Reset values:
  - Write side: full=0, almost_full=(AFULL_THRESH==0), wr_level=0, overflow=0, pointers=0.
  - Read side: empty=1, almost_empty=1, rd_level=0, rd_valid=0, rd_data=0, underflow=0, pointers=0.
  - Memory is not reset.
- Reset mid-operation: flushing requires both resets asserted with overlapping intervals for at least SYNC_STAGES+1 cycles of the slower clock. Asserting only one domain's reset is unsupported; the contents are undefined after it.

Optional Feature:
- Macro ASYNC_FIFO_FWFT_EN.
- When defined: an output staging register presents the head word.
  - rd_valid=1 means rd_data holds that word, and empty = !rd_valid.
  - rd_en && rd_valid pops the word; the next word loads on the same edge if the memory holds one.
  - A word reaches rd_data SYNC_STAGES+3 rd_clk edges after its write into an empty FIFO.
  - rd_level includes the staged word. Underflow condition is rd_en && !rd_valid.
- When undefined: standard mode as described under Behaviour.

Test Plan:
- Defaults, wr_clk 100 MHz and rd_clk 37 MHz: write 0x00..0x0F with no reads. Expected: full=1 after the 16th write, wr_level=16, almost_full from wr_level=14. Then read all 16. Expected: data 0x00..0x0F in order, then empty=1 and underflow=0.
- Full FIFO, one extra wr_en with 0xAA. Expected: overflow=1, the FIFO still reads back 0x00..0x0F. Then ovf_clr pulse. Expected: overflow=0.
- Empty FIFO, rd_en high for 1 cycle. Expected: underflow=1, rd_valid stays 0, pointers unchanged.
- Continuous random write/read for 10000 words with both clock ratios (fast-write and fast-read). Expected: no loss or duplication, full/empty never violated, wr_level <= 16.
- Write 5 words, assert both resets for 8 slow cycles. Expected after release: empty=1, full=0, both levels 0, and the first new word written reads back first.
- With ASYNC_FIFO_FWFT_EN: single write of 0x5C into an empty FIFO. Expected: rd_valid=1 and rd_data=0x5C with no rd_en, within 5 rd_clk edges. One rd_en cycle then gives rd_valid=0 and empty=1.

Source files
------------

// File: rtl/async_fifo_lvl.sv
`timescale 1ns/1ps
// async_fifo_lvl: dual-clock gray-pointer FIFO with per-domain fill levels, thresholds and sticky errors.
// Define ASYNC_FIFO_FWFT_EN for first-word-fall-through reads through an output staging register.
module async_fifo_lvl #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int AFULL_THRESH  = (1 << ADDR_W) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic              wr_clk,
  input  logic              wr_reset_n,
  input  logic              rd_clk,
  input  logic              rd_reset_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow,
  input  logic              ovf_clr,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_level,
  output logic              underflow,
  input  logic              udf_clr
);
  localparam int              DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AF_T  = (ADDR_W+1)'(AFULL_THRESH);
  localparam logic [ADDR_W:0] AE_T  = (ADDR_W+1)'(AEMPTY_THRESH);

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W-1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0] wbin, wgray, wbin_next, wgray_next, wlvl_next, rgray_s;
  logic [ADDR_W:0] rbin, rgray, rbin_next, rgray_next, rlvl_next, wgray_s;
  logic [SYNC_STAGES-1:0][ADDR_W:0] rgray_sync_q, wgray_sync_q;
  logic wr_acc, full_next;
  logic mem_empty, mem_rd, rd_valid_next, rd_err, stage_cnt;

  // ---------------- write domain ----------------
  assign wr_acc     = wr_en && !full;
  assign wbin_next  = wbin + {{ADDR_W{1'b0}}, wr_acc};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;
  assign rgray_s    = rgray_sync_q[SYNC_STAGES-1];
  assign wlvl_next  = wbin_next - gray2bin(rgray_s);
  // Full when the write pointer has lapped the read pointer by exactly one wrap.
  assign full_next  = (wgray_next == {~rgray_s[ADDR_W:ADDR_W-1], rgray_s[ADDR_W-2:0]});

  always_ff @(posedge wr_clk or negedge wr_reset_n) begin
    if (!wr_reset_n) begin
      rgray_sync_q <= '0;
      wbin         <= '0;
      wgray        <= '0;
      full         <= 1'b0;
      almost_full  <= (AFULL_THRESH == 0);
      wr_level     <= '0;
      overflow     <= 1'b0;
    end else begin
      rgray_sync_q <= {rgray_sync_q[SYNC_STAGES-2:0], rgray};
      wbin         <= wbin_next;
      wgray        <= wgray_next;
      full         <= full_next;
      almost_full  <= (wlvl_next >= AF_T);
      wr_level     <= wlvl_next;
      overflow     <= (wr_en && full) || (overflow && !ovf_clr);
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_acc) mem[wbin[ADDR_W-1:0]] <= wr_data;
  end

  // ---------------- read domain ----------------
`ifdef ASYNC_FIFO_FWFT_EN
  // Refill the staging register whenever it is empty or being popped this cycle.
  assign mem_rd        = !mem_empty && (!rd_valid || rd_en);
  assign rd_valid_next = mem_rd || (rd_valid && !rd_en);
  assign rd_err        = rd_en && !rd_valid;
  assign stage_cnt     = rd_valid_next;
  assign empty         = !rd_valid;
`else
  assign mem_rd        = rd_en && !mem_empty;
  assign rd_valid_next = mem_rd;
  assign rd_err        = rd_en && mem_empty;
  assign stage_cnt     = 1'b0;
  assign empty         = mem_empty;
`endif

  assign rbin_next  = rbin + {{ADDR_W{1'b0}}, mem_rd};
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;
  assign wgray_s    = wgray_sync_q[SYNC_STAGES-1];
  assign rlvl_next  = gray2bin(wgray_s) - rbin_next + {{ADDR_W{1'b0}}, stage_cnt};

  always_ff @(posedge rd_clk or negedge rd_reset_n) begin
    if (!rd_reset_n) begin
      wgray_sync_q <= '0;
      rbin         <= '0;
      rgray        <= '0;
      mem_empty    <= 1'b1;
      almost_empty <= 1'b1;
      rd_level     <= '0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      underflow    <= 1'b0;
    end else begin
      wgray_sync_q <= {wgray_sync_q[SYNC_STAGES-2:0], wgray};
      rbin         <= rbin_next;
      rgray        <= rgray_next;
      mem_empty    <= (rgray_next == wgray_s);
      almost_empty <= (rlvl_next <= AE_T);
      rd_level     <= rlvl_next;
      rd_valid     <= rd_valid_next;
      if (mem_rd) rd_data <= mem[rbin[ADDR_W-1:0]];
      underflow    <= rd_err || (underflow && !udf_clr);
    end
  end

endmodule
